// File: rtl/mips_mc_pkg.sv
// Shared types and constants for the multicycle MIPS main controller.
package mips_mc_pkg;

  localparam int unsigned OPC_W    = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned CNT_W    = 32;
  localparam int unsigned STATE_W  = 4;
  localparam int unsigned ALU_OP_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_EXEC_R = 4'd2,
    ST_EXEC_I = 4'd3,
    ST_ADDR   = 4'd4,
    ST_MEM_RD = 4'd5,
    ST_MEM_WR = 4'd6,
    ST_WB_R   = 4'd7,
    ST_WB_I   = 4'd8,
    ST_WB_LW  = 4'd9,
    ST_BRANCH = 4'd10,
    ST_JUMP   = 4'd11,
    ST_HALT   = 4'd12
  } state_e;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4
  } alu_op_e;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [1:0] SRC_B_REG     = 2'd0;
  localparam logic [1:0] SRC_B_FOUR    = 2'd1;
  localparam logic [1:0] SRC_B_IMM     = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPC_W-1:0] OP_J     = 6'h02;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPC_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OPC_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

endpackage

// File: rtl/mc_alu_decode.sv
// ALU operation decode: funct for R-type, opcode for I-type, plus legality.
module mc_alu_decode
  import mips_mc_pkg::*;
(
  input  logic                rtype,
  input  logic [OPC_W-1:0]    opcode,
  input  logic [FUNCT_W-1:0]  funct,
  output logic [ALU_OP_W-1:0] alu_op_c,
  output logic                legal_c
);

  // Select the operation from funct or opcode and flag unsupported encodings.
  always_comb begin
    alu_op_c = ALU_OP_W'(ALU_ADD);
    legal_c  = 1'b0;
    if (rtype) begin
      case (funct)
        FN_ADD: begin alu_op_c = ALU_OP_W'(ALU_ADD); legal_c = 1'b1; end
        FN_SUB: begin alu_op_c = ALU_OP_W'(ALU_SUB); legal_c = 1'b1; end
        FN_AND: begin alu_op_c = ALU_OP_W'(ALU_AND); legal_c = 1'b1; end
        FN_OR:  begin alu_op_c = ALU_OP_W'(ALU_OR);  legal_c = 1'b1; end
        FN_SLT: begin alu_op_c = ALU_OP_W'(ALU_SLT); legal_c = 1'b1; end
        default: ;
      endcase
    end else begin
      case (opcode)
        OP_ADDI: begin alu_op_c = ALU_OP_W'(ALU_ADD); legal_c = 1'b1; end
        OP_ANDI: begin alu_op_c = ALU_OP_W'(ALU_AND); legal_c = 1'b1; end
        OP_ORI:  begin alu_op_c = ALU_OP_W'(ALU_OR);  legal_c = 1'b1; end
        OP_SLTI: begin alu_op_c = ALU_OP_W'(ALU_SLT); legal_c = 1'b1; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main controller: fetch/decode/execute/memory/writeback FSM.
// Optional feature macro: MC_PERF_CNT_EN adds instr_cnt / cycle_cnt counters.
// Controls are decoded from the state; the memory handshake and the branch
// zero flag act in the same cycle, and reset forces every output low.
module mips_mc_control
  import mips_mc_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [OPC_W-1:0]    opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_we,
  output logic                pc_we,
  output logic                reg_we,
  output logic [1:0]          pc_src,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                retire,
  output logic                halted,
  output logic [STATE_W-1:0]  state_o
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    instr_cnt,
  output logic [CNT_W-1:0]    cycle_cnt
`endif
);

  state_e                state;
  state_e                state_next;
  logic [ALU_OP_W-1:0]   dec_alu_op;
  logic                  dec_legal;

  mc_alu_decode u_alu_decode (
    .rtype    (opcode == OP_RTYPE),
    .opcode   (opcode),
    .funct    (funct),
    .alu_op_c (dec_alu_op),
    .legal_c  (dec_legal)
  );

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_FETCH;
    else       state <= state_next;
  end

  // Next-state and control decode; reset blanks every output in its cycle.
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    reg_we     = 1'b0;
    pc_src     = PC_SRC_ALU;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_REG;
    alu_op     = ALU_OP_W'(ALU_ADD);
    retire     = 1'b0;
    halted     = 1'b0;
    state_o    = STATE_W'(state);

    case (state)
      ST_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRC_B_FOUR;
        if (mem_ready) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_src_b = SRC_B_IMM_SH2;
        case (opcode)
          OP_RTYPE:                         state_next = ST_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next = ST_EXEC_I;
          OP_LW, OP_SW:                     state_next = ST_ADDR;
          OP_BEQ, OP_BNE:                   state_next = ST_BRANCH;
          OP_J:                             state_next = ST_JUMP;
          default:                          state_next = ST_HALT;
        endcase
      end
      ST_EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_op     = dec_alu_op;
        state_next = dec_legal ? ST_WB_R : ST_HALT;
      end
      ST_EXEC_I: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRC_B_IMM;
        alu_op     = dec_alu_op;
        state_next = ST_WB_I;
      end
      ST_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRC_B_IMM;
        state_next = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_next = ST_WB_LW;
      end
      ST_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_WB_R: begin
        reg_we     = 1'b1;
        reg_dst    = 1'b1;
        retire     = 1'b1;
        state_next = ST_FETCH;
      end
      ST_WB_I: begin
        reg_we     = 1'b1;
        retire     = 1'b1;
        state_next = ST_FETCH;
      end
      ST_WB_LW: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_next = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_OP_W'(ALU_SUB);
        pc_src     = PC_SRC_ALUOUT;
        pc_we      = (opcode == OP_BNE) ? ~zero : zero;
        retire     = 1'b1;
        state_next = ST_FETCH;
      end
      ST_JUMP: begin
        pc_we      = 1'b1;
        pc_src     = PC_SRC_JUMP;
        retire     = 1'b1;
        state_next = ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: state_next = ST_HALT;
    endcase

    if (reset) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      reg_we     = 1'b0;
      pc_src     = PC_SRC_ALU;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRC_B_REG;
      alu_op     = ALU_OP_W'(ALU_ADD);
      retire     = 1'b0;
      halted     = 1'b0;
      state_o    = '0;
    end
  end

`ifdef MC_PERF_CNT_EN
  // Performance counters; both hold while halted and wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_cnt <= '0;
      cycle_cnt <= '0;
    end else begin
      if (state != ST_HALT) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire)           instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed self-checking bench for mips_mc_control.
// Counter checks are compiled only when MC_PERF_CNT_EN is defined.
module tb_mips_mc_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = 6'h00;
  logic [5:0]  funct = 6'h20;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        mem_req, mem_we, iord, ir_we, pc_we, reg_we;
  logic [1:0]  pc_src;
  logic        reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]  alu_src_b;
  logic [3:0]  alu_op;
  logic        retire, halted;
  logic [3:0]  state_o;
`ifdef MC_PERF_CNT_EN
  logic [31:0] instr_cnt, cycle_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [22:0] outs;
  assign outs = {mem_req, mem_we, iord, ir_we, pc_we, reg_we, pc_src, reg_dst,
                 mem_to_reg, alu_src_a, alu_src_b, alu_op, retire, halted, state_o};

  mips_mc_control dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .reg_we     (reg_we),
    .pc_src     (pc_src),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .retire     (retire),
    .halted     (halted),
    .state_o    (state_o)
`ifdef MC_PERF_CNT_EN
    ,
    .instr_cnt  (instr_cnt),
    .cycle_cnt  (cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Apply one reset cycle; on return the current cycle is FETCH.
  task automatic do_reset();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; opcode = 6'h2B;
    next_cycle();
    next_cycle();
    #1;
    checks++;
    if (outs !== 23'd0) begin
      errors++; $display("FAIL reset_outs got %h exp %h", outs, 23'd0);
    end
    next_cycle();
    reset = 1'b0;
    #1;
    checks++;
    if ({mem_req, iord, state_o} !== {1'b1, 1'b0, 4'd0}) begin
      errors++; $display("FAIL reset_first_req got %b exp %b", {mem_req, iord, state_o}, 6'b100000);
    end
  endtask

  task automatic test_add();
    opcode = 6'h00; funct = 6'h20; mem_ready = 1'b1; zero = 1'b0;
    do_reset();
    #1;
    checks++;
    if ({mem_req, iord, ir_we, pc_we, pc_src, alu_src_b, retire} !== 9'b1_0_1_1_00_01_0) begin
      errors++; $display("FAIL add_c1 got %b exp %b", {mem_req, iord, ir_we, pc_we, pc_src, alu_src_b, retire}, 9'b101100010);
    end
    next_cycle(); #1;
    checks++;
    if ({state_o, alu_src_a, alu_src_b, alu_op} !== {4'd1, 1'b0, 2'd3, 4'd0}) begin
      errors++; $display("FAIL add_c2 got %b exp %b", {state_o, alu_src_a, alu_src_b, alu_op}, {4'd1, 1'b0, 2'd3, 4'd0});
    end
    next_cycle(); #1;
    checks++;
    if ({state_o, alu_src_a, alu_src_b, alu_op, reg_we} !== {4'd2, 1'b1, 2'd0, 4'd0, 1'b0}) begin
      errors++; $display("FAIL add_c3 got %b exp %b", {state_o, alu_src_a, alu_src_b, alu_op, reg_we}, {4'd2, 1'b1, 2'd0, 4'd0, 1'b0});
    end
    next_cycle(); #1;
    checks++;
    if ({reg_we, reg_dst, mem_to_reg, retire, mem_req} !== 5'b11010) begin
      errors++; $display("FAIL add_c4 got %b exp %b", {reg_we, reg_dst, mem_to_reg, retire, mem_req}, 5'b11010);
    end
    next_cycle(); #1;
    checks++;
    if ({state_o, mem_req} !== {4'd0, 1'b1}) begin
      errors++; $display("FAIL add_c5 got %b exp %b", {state_o, mem_req}, {4'd0, 1'b1});
    end
  endtask

  task automatic test_alu_ops();
    logic [5:0] opc [8] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0A};
    logic [5:0] fn  [8] = '{6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F, 6'h00, 6'h20, 6'h22};
    logic [3:0] est [8] = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3};
    logic [3:0] eop [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd2, 4'd3, 4'd4};
    logic [1:0] esb [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2};
    logic [3:0] ewb [8] = '{4'd7, 4'd7, 4'd7, 4'd7, 4'd8, 4'd8, 4'd8, 4'd8};
    logic       edst[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      opcode = opc[i]; funct = fn[i]; mem_ready = 1'b1;
      do_reset();
      next_cycle();
      next_cycle(); #1;
      checks++;
      if ({state_o, alu_op, alu_src_a, alu_src_b} !== {est[i], eop[i], 1'b1, esb[i]}) begin
        errors++; $display("FAIL alu_op[%0d] got %b exp %b", i, {state_o, alu_op, alu_src_a, alu_src_b}, {est[i], eop[i], 1'b1, esb[i]});
      end
      next_cycle(); #1;
      checks++;
      if ({state_o, reg_we, reg_dst, retire} !== {ewb[i], 1'b1, edst[i], 1'b1}) begin
        errors++; $display("FAIL alu_wb[%0d] got %b exp %b", i, {state_o, reg_we, reg_dst, retire}, {ewb[i], 1'b1, edst[i], 1'b1});
      end
    end
    opcode = 6'h00; funct = 6'h21;
    do_reset();
    next_cycle(); next_cycle(); next_cycle(); #1;
    checks++;
    if ({state_o, halted, reg_we} !== {4'd12, 1'b1, 1'b0}) begin
      errors++; $display("FAIL bad_funct got %b exp %b", {state_o, halted, reg_we}, {4'd12, 1'b1, 1'b0});
    end
  endtask

  task automatic test_cpi();
    logic [5:0] opc [8] = '{6'h00, 6'h08, 6'h2B, 6'h23, 6'h04, 6'h05, 6'h02, 6'h0D};
    int         exp_cpi [8] = '{4, 4, 4, 5, 3, 3, 3, 4};
    int n;
    for (int i = 0; i < 8; i++) begin
      opcode = opc[i]; funct = 6'h20; mem_ready = 1'b1;
      do_reset();
      n = 1;
      #1;
      while (retire !== 1'b1 && n < 50) begin
        next_cycle(); #1;
        n++;
      end
      checks++;
      if (n != exp_cpi[i]) begin
        errors++; $display("FAIL cpi[op=%h] got %0d exp %0d", opc[i], n, exp_cpi[i]);
      end
    end
  endtask

  task automatic test_fetch_wait();
    opcode = 6'h00; funct = 6'h25;
    mem_ready = 1'b0;
    do_reset();
    #1;
    checks++;
    if ({mem_req, ir_we, pc_we, state_o} !== {3'b100, 4'd0}) begin
      errors++; $display("FAIL fetch_wait got %b exp %b", {mem_req, ir_we, pc_we, state_o}, {3'b100, 4'd0});
    end
    next_cycle();
    mem_ready = 1'b1; #1;
    checks++;
    if ({ir_we, pc_we, state_o} !== {2'b11, 4'd0}) begin
      errors++; $display("FAIL fetch_done got %b exp %b", {ir_we, pc_we, state_o}, {2'b11, 4'd0});
    end
    next_cycle();
    mem_ready = 1'b0; #1;
    next_cycle(); #1;
    next_cycle(); #1;
    checks++;
    if ({state_o, retire, mem_req} !== {4'd7, 1'b1, 1'b0}) begin
      errors++; $display("FAIL ready_ignored got %b exp %b", {state_o, retire, mem_req}, {4'd7, 1'b1, 1'b0});
    end
  endtask

  task automatic test_lw_wait();
    logic early_we;
    logic bad_mem;
    early_we = 1'b0; bad_mem = 1'b0;
    opcode = 6'h23; mem_ready = 1'b1;
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) next_cycle();
      mem_ready = (c >= 4 && c <= 6) ? 1'b0 : 1'b1;
      #1;
      if (c < 8 && reg_we === 1'b1) early_we = 1'b1;
      if (c >= 4 && c <= 7 && {state_o, mem_req, iord, mem_we} !== {4'd5, 3'b110}) bad_mem = 1'b1;
      if (c < 8 && retire === 1'b1) early_we = 1'b1;
    end
    checks++;
    if ({reg_we, mem_to_reg, retire, state_o} !== {3'b111, 4'd9}) begin
      errors++; $display("FAIL lw_wb got %b exp %b", {reg_we, mem_to_reg, retire, state_o}, {3'b111, 4'd9});
    end
    checks++;
    if (early_we !== 1'b0) begin
      errors++; $display("FAIL lw_early_write got %b exp 0", early_we);
    end
    checks++;
    if (bad_mem !== 1'b0) begin
      errors++; $display("FAIL lw_mem_rd got %b exp 0", bad_mem);
    end
  endtask

  task automatic test_branch();
    logic [5:0] opc [4] = '{6'h04, 6'h04, 6'h05, 6'h05};
    logic       z   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       epw [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      opcode = opc[i]; zero = z[i]; mem_ready = 1'b1;
      do_reset();
      next_cycle(); next_cycle(); #1;
      checks++;
      if ({state_o, pc_we, pc_src, alu_op, alu_src_a, retire} !== {4'd10, epw[i], 2'd1, 4'd1, 1'b1, 1'b1}) begin
        errors++; $display("FAIL branch[%0d] got %b exp %b", i, {state_o, pc_we, pc_src, alu_op, alu_src_a, retire}, {4'd10, epw[i], 2'd1, 4'd1, 1'b1, 1'b1});
      end
    end
    zero = 1'b0;
    opcode = 6'h02;
    do_reset();
    next_cycle(); next_cycle(); #1;
    checks++;
    if ({state_o, pc_we, pc_src, retire} !== {4'd11, 1'b1, 2'd2, 1'b1}) begin
      errors++; $display("FAIL jump got %b exp %b", {state_o, pc_we, pc_src, retire}, {4'd11, 1'b1, 2'd2, 1'b1});
    end
  endtask

  task automatic test_halt();
    logic leak;
    logic lost;
    leak = 1'b0; lost = 1'b0;
    opcode = 6'h3F; mem_ready = 1'b1;
    do_reset();
    next_cycle(); next_cycle(); #1;
    checks++;
    if ({state_o, halted} !== {4'd12, 1'b1}) begin
      errors++; $display("FAIL halt_enter got %b exp %b", {state_o, halted}, {4'd12, 1'b1});
    end
    for (int c = 0; c < 20; c++) begin
      next_cycle();
      mem_ready = c[0]; zero = c[1]; opcode = 6'h00;
      #1;
      if ({mem_req, mem_we, ir_we, pc_we, reg_we, retire} !== 6'd0) leak = 1'b1;
      if (halted !== 1'b1) lost = 1'b1;
    end
    checks++;
    if ({leak, lost} !== 2'b00) begin
      errors++; $display("FAIL halt_hold got %b exp 00", {leak, lost});
    end
    next_cycle();
    reset = 1'b1; #1;
    checks++;
    if (outs !== 23'd0) begin
      errors++; $display("FAIL halt_reset_outs got %h exp 0", outs);
    end
    next_cycle();
    reset = 1'b0; mem_ready = 1'b1; #1;
    checks++;
    if ({state_o, mem_req, halted} !== {4'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL halt_exit got %b exp %b", {state_o, mem_req, halted}, {4'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_reset_mem_wr();
    opcode = 6'h2B; mem_ready = 1'b1;
    do_reset();
    next_cycle(); next_cycle(); next_cycle();
    mem_ready = 1'b0; #1;
    checks++;
    if ({state_o, mem_req, mem_we, iord, retire} !== {4'd6, 4'b1110}) begin
      errors++; $display("FAIL mem_wr_wait got %b exp %b", {state_o, mem_req, mem_we, iord, retire}, {4'd6, 4'b1110});
    end
    next_cycle();
    reset = 1'b1; mem_ready = 1'b1; #1;
    checks++;
    if ({mem_req, mem_we, retire, pc_we, reg_we} !== 5'd0) begin
      errors++; $display("FAIL mem_wr_reset got %b exp 00000", {mem_req, mem_we, retire, pc_we, reg_we});
    end
    next_cycle();
    reset = 1'b0; #1;
    checks++;
    if ({state_o, mem_req, mem_we} !== {4'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL mem_wr_after got %b exp %b", {state_o, mem_req, mem_we}, {4'd0, 1'b1, 1'b0});
    end
  endtask

`ifdef MC_PERF_CNT_EN
  task automatic test_perf();
    logic [5:0] opc [10] = '{6'h00, 6'h23, 6'h2B, 6'h02, 6'h00, 6'h23, 6'h00, 6'h2B, 6'h02, 6'h00};
    int n;
    mem_ready = 1'b1; funct = 6'h20;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      opcode = opc[i];
      n = 1; #1;
      while (retire !== 1'b1 && n < 20) begin
        next_cycle(); #1;
        n++;
      end
      next_cycle();
    end
    #1;
    checks++;
    if ({instr_cnt, cycle_cnt} !== {32'd10, 32'd40}) begin
      errors++; $display("FAIL perf_cnt got %0d/%0d exp 10/40", instr_cnt, cycle_cnt);
    end
    opcode = 6'h3F;
    for (int c = 0; c < 6; c++) next_cycle();
    #1;
    checks++;
    if ({instr_cnt, cycle_cnt} !== {32'd10, 32'd42}) begin
      errors++; $display("FAIL perf_freeze got %0d/%0d exp 10/42", instr_cnt, cycle_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_cpi();
    test_fetch_wait();
    test_lw_wait();
    test_branch();
    test_halt();
    test_reset_mem_wr();
`ifdef MC_PERF_CNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
